// File: rtl/iob_eth_mii_tx_ser_pkg.sv
// Shared encodings and constants for the MII TX nibble serializer.
package iob_eth_mii_tx_ser_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned NIB_CNT_W = 5;

  localparam logic [NIBBLE_W-1:0] PREAMBLE_NIBBLE = 4'h5;
  localparam logic [NIBBLE_W-1:0] SFD_HI_NIBBLE   = 4'hD;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    SFD_LO = 3'd2,
    SFD_HI = 3'd3,
    D_LO   = 3'd4,
    D_HI   = 3'd5,
    IFG    = 3'd6
  } state_t;

endpackage

// File: rtl/iob_eth_mii_tx_ser_reg.sv
// Async active-low reset flop with clock enable; resets to zero.
module iob_eth_mii_tx_ser_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         arst_n_i,
  input  logic         cke_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      q_o <= '0;
    end else if (cke_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/iob_eth_mii_tx_ser.sv
// MII TX serializer: preamble/SFD insertion, bytes sent low nibble first.
// Optional inter-frame gap state enabled by IOB_ETH_MII_TX_SER_IFG_EN.
module iob_eth_mii_tx_ser
  import iob_eth_mii_tx_ser_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic [BYTE_W-1:0]   data_i,
  input  logic                valid_i,
  input  logic                last_i,
  output logic                ready_o,
  output logic [NIBBLE_W-1:0] mii_txd_o,
  output logic                mii_tx_en_o,
  output logic                busy_o,
  output logic                underrun_o
);

  if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15 || IFG_BYTES < 1 || IFG_BYTES > 63) begin : g_param_chk
    $error("iob_eth_mii_tx_ser: PREAMBLE_LEN or IFG_BYTES out of range");
  end

  localparam logic [NIB_CNT_W-1:0] PRE_LAST = NIB_CNT_W'(2 * PREAMBLE_LEN - 1);

`ifdef IOB_ETH_MII_TX_SER_IFG_EN
  localparam int unsigned GAP_CNT_W = 7;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(2 * IFG_BYTES - 1);
  localparam state_t FRAME_END = IFG;
`else
  localparam state_t FRAME_END = IDLE;
`endif

  logic [STATE_W-1:0]   state_q;
  state_t               state;
  state_t               state_d;
  logic [BYTE_W-1:0]    byte_q, byte_d;
  logic                 last_q, last_d;
  logic [NIB_CNT_W-1:0] nib_q, nib_d;
  logic                 ready_c;
  logic                 xfer;

  assign state = state_t'(state_q);

  iob_eth_mii_tx_ser_reg #(.W(STATE_W)) u_state_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .d_i(STATE_W'(state_d)), .q_o(state_q)
  );
  iob_eth_mii_tx_ser_reg #(.W(BYTE_W)) u_byte_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .d_i(byte_d), .q_o(byte_q)
  );
  iob_eth_mii_tx_ser_reg #(.W(1)) u_last_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .d_i(last_d), .q_o(last_q)
  );
  iob_eth_mii_tx_ser_reg #(.W(NIB_CNT_W)) u_nib_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .d_i(nib_d), .q_o(nib_q)
  );

`ifdef IOB_ETH_MII_TX_SER_IFG_EN
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  iob_eth_mii_tx_ser_reg #(.W(GAP_CNT_W)) u_gap_reg (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .d_i(gap_d), .q_o(gap_q)
  );
`endif

  // Ready depends only on state and the held last flag; masked while reset is asserted.
  assign ready_c    = (state == IDLE) || ((state == D_HI) && !last_q);
  assign xfer       = cke_i && valid_i && ready_c;
  assign ready_o    = arst_n_i && ready_c;
  assign busy_o     = (state != IDLE);
  assign underrun_o = arst_n_i && cke_i && (state == D_HI) && !last_q && !valid_i;

  always_comb begin
    state_d     = state;
    byte_d      = byte_q;
    last_d      = last_q;
    nib_d       = nib_q;
    mii_txd_o   = '0;
    mii_tx_en_o = 1'b0;
`ifdef IOB_ETH_MII_TX_SER_IFG_EN
    gap_d       = gap_q;
`endif
    unique case (state)
      IDLE: begin
        if (xfer) begin
          byte_d  = data_i;
          last_d  = last_i;
          nib_d   = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        mii_tx_en_o = 1'b1;
        mii_txd_o   = PREAMBLE_NIBBLE;
        if (nib_q == PRE_LAST) begin
          state_d = SFD_LO;
        end else begin
          nib_d = nib_q + NIB_CNT_W'(1);
        end
      end
      SFD_LO: begin
        mii_tx_en_o = 1'b1;
        mii_txd_o   = PREAMBLE_NIBBLE;
        state_d     = SFD_HI;
      end
      SFD_HI: begin
        mii_tx_en_o = 1'b1;
        mii_txd_o   = SFD_HI_NIBBLE;
        state_d     = D_LO;
      end
      D_LO: begin
        mii_tx_en_o = 1'b1;
        mii_txd_o   = byte_q[3:0];
        state_d     = D_HI;
      end
      D_HI: begin
        mii_tx_en_o = 1'b1;
        mii_txd_o   = byte_q[7:4];
        // Either the next byte is ready now, or the frame ends (normally or by underrun).
        if (xfer) begin
          byte_d  = data_i;
          last_d  = last_i;
          state_d = D_LO;
        end else begin
          state_d = FRAME_END;
`ifdef IOB_ETH_MII_TX_SER_IFG_EN
          gap_d   = '0;
`endif
        end
      end
`ifdef IOB_ETH_MII_TX_SER_IFG_EN
      IFG: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_eth_mii_tx_ser.sv
// Self-checking bench for iob_eth_mii_tx_ser with a cycle-formula reference model.
module tb_iob_eth_mii_tx_ser;

  localparam int P    = 7;
  localparam int IFGB = 12;
`ifdef IOB_ETH_MII_TX_SER_IFG_EN
  localparam int GAP = 2 * IFGB;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       cke, rst_n, valid, last;
  logic [7:0] data;
  logic       ready, en, busy, und;
  logic [3:0] txd;

  int passed = 0;
  int total  = 0;
  logic [7:0] fb [0:31];

  always #5 clk = ~clk;

  iob_eth_mii_tx_ser #(.PREAMBLE_LEN(P), .IFG_BYTES(IFGB)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(rst_n), .data_i(data), .valid_i(valid),
    .last_i(last), .ready_o(ready), .mii_txd_o(txd), .mii_tx_en_o(en),
    .busy_o(busy), .underrun_o(und)
  );

  // Expected {ready,busy,underrun,tx_en,txd} at cycle t of a frame of n bytes
  // (t=0 is the accepting IDLE cycle); fl=0 means the stream dries up after byte n-1.
  function automatic logic [7:0] model_out(input int t, input int n, input bit fl);
    int end_t;
    int j;
    int i;
    logic [7:0] r;
    logic [7:0] b;
    end_t = 2 * P + 2 + 2 * n;
    if (t == 0)                r = {1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    else if (t <= 2 * P + 1)   r = {1'b0, 1'b1, 1'b0, 1'b1, 4'h5};
    else if (t == 2 * P + 2)   r = {1'b0, 1'b1, 1'b0, 1'b1, 4'hD};
    else if (t <= end_t) begin
      j = t - (2 * P + 3);
      i = j / 2;
      b = fb[i];
      if (j % 2 == 0) r = {1'b0, 1'b1, 1'b0, 1'b1, b[3:0]};
      else r = {(i < n - 1) || !fl, 1'b1, (i == n - 1) && !fl, 1'b1, b[7:4]};
    end
    else if (t <= end_t + GAP) r = {1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    else                       r = {1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    return r;
  endfunction

  task automatic drain(input string tag);
    bit idle;
    idle  = 1'b0;
    valid = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        idle = 1'b1;
        break;
      end
    end
    total++;
    if (!idle) $display("FAIL %s drain: busy got %b want 0", tag, busy);
    else passed++;
    @(posedge clk); #1;
  endtask

  // Drives one frame (valid held while bytes remain), then optionally offers pb after the frame.
  task automatic run_frame(input int n, input bit fl, input bit post, input logic [7:0] pb,
                           input string tag);
    int idx;
    int end_t;
    logic [7:0] exp_v;
    logic [7:0] got_v;
    idx   = 0;
    end_t = 2 * P + 2 + 2 * n;
    for (int t = 0; t <= end_t + GAP + 1; t++) begin
      if (idx < n) begin
        valid = 1'b1; data = fb[idx]; last = fl && (idx == n - 1);
      end else if (post && t > end_t) begin
        valid = 1'b1; data = pb; last = 1'b1;
      end else begin
        valid = 1'b0; data = 8'($urandom); last = 1'($urandom);
      end
      @(negedge clk);
      exp_v = model_out(t, n, fl);
      got_v = {ready, busy, und, en, txd};
      total++;
      if (got_v !== exp_v)
        $display("FAIL %s t=%0d {rdy,busy,und,en,txd} got %b want %b", tag, t, got_v, exp_v);
      else passed++;
      if (exp_v[7] && valid) idx++;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (post) begin
      @(negedge clk);
      total++;
      if (!(en === 1'b1 && txd === 4'h5 && busy === 1'b1))
        $display("FAIL %s restart: en/txd/busy got %b/%h/%b want 1/5/1", tag, en, txd, busy);
      else passed++;
      drain(tag);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; valid = 1'b1; data = 8'hFF; last = 1'b0;
    #1;
    total++;
    if ({ready, busy, und, en, txd} !== 8'h00)
      $display("FAIL reset outputs got %b want 00000000", {ready, busy, und, en, txd});
    else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({ready, busy, en} !== 3'b100)
      $display("FAIL reset_release rdy/busy/en got %b want 100", {ready, busy, en});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    fb[0] = 8'hA3;
    run_frame(1, 1'b1, 1'b0, 8'h00, "single");
  endtask

  task automatic test_back_to_back;
    fb[0] = 8'h12; fb[1] = 8'h34; fb[2] = 8'h56;
    run_frame(3, 1'b1, 1'b0, 8'h00, "b2b");
  endtask

  task automatic test_underrun;
    fb[0] = 8'h11;
    run_frame(1, 1'b0, 1'b1, 8'h22, "underrun");
  endtask

  task automatic test_ifg;
    fb[0] = 8'h5A; fb[1] = 8'hC7;
    run_frame(2, 1'b1, 1'b1, 8'h99, "ifg");
  endtask

  task automatic test_reset_mid;
    fb[0] = 8'($urandom);
    valid = 1'b1; data = fb[0]; last = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (2 * P + 2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (!(en === 1'b1 && txd === fb[0][3:0]))
      $display("FAIL rst_mid d_lo en/txd got %b/%h want 1/%h", en, txd, fb[0][3:0]);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ready, busy, en, txd} !== 7'h00)
      $display("FAIL rst_mid async rdy/busy/en/txd got %b want 0000000", {ready, busy, en, txd});
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
    run_frame(4, 1'b1, 1'b0, 8'h00, "rst_mid_restart");
  endtask

  task automatic test_cke;
    logic [3:0] seq[$];
    logic [7:0] prev_v;
    logic [7:0] cur_v;
    logic [3:0] exp_seq[$];
    bit prev_cke;
    bit seen;
    bit done;
    int bad;
    int pre_cnt;
    fb[0] = 8'($urandom);
    seen = 1'b0; done = 1'b0; prev_cke = 1'b1; prev_v = '0;
    cke = 1'b0; valid = 1'b1; data = fb[0]; last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({busy, en} !== 2'b00) $display("FAIL cke_gate busy/en got %b want 00", {busy, en});
    else passed++;
    @(posedge clk); #1;
    cke = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int c = 1; c < 100; c++) begin
      cke = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      cur_v = {ready, busy, und, en, txd};
      if (!prev_cke) begin
        total++;
        if (cur_v !== prev_v) $display("FAIL cke_freeze c=%0d got %b want %b", c, cur_v, prev_v);
        else passed++;
      end
      if (cke && en) seq.push_back(txd);
      if (en) seen = 1'b1;
      if (seen && !en) begin
        done = 1'b1;
        break;
      end
      prev_v = cur_v; prev_cke = cke;
      @(posedge clk); #1;
    end
    cke = 1'b1;
    total++;
    if (!done) $display("FAIL cke_timeout frame end got 0 want 1");
    else passed++;
    if (done) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2 * P + 1; i++) exp_seq.push_back(4'h5);
    exp_seq.push_back(4'hD);
    exp_seq.push_back(fb[0][3:0]);
    exp_seq.push_back(fb[0][7:4]);
    pre_cnt = 0;
    foreach (seq[i]) if (seq[i] == 4'h5 && pre_cnt == i) pre_cnt++;
    total++;
    if (pre_cnt != 2 * P + 1) $display("FAIL cke_pre_count got %0d want %0d", pre_cnt, 2 * P + 1);
    else passed++;
    bad = (seq.size() != exp_seq.size()) ? 1 : 0;
    if (bad == 0) foreach (seq[i]) if (seq[i] !== exp_seq[i]) bad++;
    total++;
    if (bad != 0) $display("FAIL cke_seq len got %0d want %0d, %0d nibble errors", seq.size(),
                           exp_seq.size(), bad);
    else passed++;
    drain("cke");
  endtask

  task automatic test_random;
    int n;
    bit fl;
    bit post;
    for (int it = 0; it < 12; it++) begin
      n    = $urandom_range(1, 8);
      fl   = 1'($urandom_range(0, 1));
      post = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
      run_frame(n, fl, post, 8'($urandom), "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cke = 1'b1; valid = 1'b0; data = 8'h00; last = 1'b0; rst_n = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_ifg();
    test_reset_mid();
    test_cke();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
